booth_seq_divider: RTL and testbench



---
 rtl/booth_div_pkg.sv | 14 +
 rtl/div_trial_sub.sv | 13 +
 rtl/booth_seq_divider.sv | 110 +++++++++++
 tb/tb_booth_seq_divider.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_div_pkg.sv
// booth_div_pkg: shared state encoding and sizing helpers for the sequential divider.
package booth_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: combinational trial subtractor, borrow set when minuend < subtrahend.
module div_trial_sub #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/booth_seq_divider.sv
// booth_seq_divider: signed restoring divider, one shift-subtract step per clock on magnitudes,
// followed by a sign-correction cycle that registers quotient, remainder and flags.
module booth_seq_divider
    import booth_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, next;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] qmag;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH-1:0] dvd;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic             ov;
    logic             last;

    // The quotient register starts out holding the dividend magnitude and is shifted into prem.
    assign shifted = {prem[WIDTH-1:0], qmag[WIDTH-1]};
    assign last    = cnt == CW'(WIDTH - 1);
    assign busy    = state != IDLE;

    div_trial_sub #(.WIDTH(WIDTH + 1)) u_sub (
        .minuend    (shifted),
        .subtrahend ({1'b0, dmag}),
        .diff       (diff),
        .borrow     (borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        next = (state == IDLE && start) ? CALC :
               (state == CALC && last)  ? FIX  :
               (state == FIX)           ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            prem        <= '0;
            qmag        <= '0;
            dmag        <= '0;
            dvd         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz          <= 1'b0;
            ov          <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= state == FIX;
            case (state)
                IDLE: if (start) begin
                    dvd   <= dividend;
                    qmag  <= dividend[WIDTH-1] ? -dividend : dividend;
                    dmag  <= divisor[WIDTH-1] ? -divisor : divisor;
                    neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_r <= dividend[WIDTH-1];
                    dz    <= divisor == '0;
                    ov    <= dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1;
                    prem  <= '0;
                    cnt   <= '0;
                end
                CALC: begin
                    prem <= borrow ? shifted : diff;
                    qmag <= {qmag[WIDTH-2:0], ~borrow};
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    quotient    <= dz ? '1 : neg_q ? -qmag : qmag;
                    remainder   <= dz ? dvd : WIDTH'(neg_r ? -prem : prem);
                    div_by_zero <= dz;
                    overflow    <= ov;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_divider.sv
// tb_booth_seq_divider: scoreboard bench; a reference model built on integer division feeds
// a queue of expected results that a done-triggered monitor pops and compares.
module tb_booth_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    booth_seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Signed integer division truncates toward zero and % follows the dividend's sign.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int c);
        exp_t e;
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.a = a;
        e.b = b;
        e.cyc = c;
        e.dz = sb == 0;
        e.ov = sa == -128 && sb == -1;
        if (e.dz) begin
            e.q = 8'hFF;
            e.r = a;
        end else if (e.ov) begin
            e.q = 8'h80;
            e.r = 8'h00;
        end else begin
            e.q = 8'(sa / sb);
            e.r = 8'(sa % sb);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_busy_exclusive", {31'b0, done & busy}, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("quotient %02h/%02h", mon_e.a, mon_e.b), {24'b0, quotient}, {24'b0, mon_e.q});
                    chk($sformatf("remainder %02h/%02h", mon_e.a, mon_e.b), {24'b0, remainder}, {24'b0, mon_e.r});
                    chk($sformatf("div_by_zero %02h/%02h", mon_e.a, mon_e.b), {31'b0, div_by_zero}, {31'b0, mon_e.dz});
                    chk($sformatf("overflow %02h/%02h", mon_e.a, mon_e.b), {31'b0, overflow}, {31'b0, mon_e.ov});
                    chk($sformatf("done_cycle %02h/%02h", mon_e.a, mon_e.b), cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 30) begin
            n++;
            @(negedge clk);
        end
        if (n >= 30) begin
            n_chk++;
            n_fail++;
            $display("FAIL busy_timeout: got busy still high after %0d cycles expected idle", n);
        end
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        exp_q.push_back(model(a, b, cyc + 10));
        @(negedge clk);
        start = 1'b0;
        dividend = 8'($urandom);
        divisor = 8'($urandom);
        wait_idle(n);
        chk($sformatf("busy_cycles %02h/%02h", a, b), n, 9);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " quotient"}, {24'b0, quotient}, 0);
        chk({tag, " remainder"}, {24'b0, remainder}, 0);
        chk({tag, " busy"}, {31'b0, busy}, 0);
        chk({tag, " done"}, {31'b0, done}, 0);
        chk({tag, " div_by_zero"}, {31'b0, div_by_zero}, 0);
        chk({tag, " overflow"}, {31'b0, overflow}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int k;
        logic [7:0] a;
        logic [7:0] b;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        run(8'h64, 8'h07);
        run(8'h9C, 8'h07);
        run(8'h64, 8'hF9);
        run(8'h25, 8'h00);
        run(8'h64, 8'h07);
        run(8'h80, 8'hFF);
        run(8'h80, 8'h01);
        run(8'h00, 8'h05);
        run(8'h7F, 8'h80);

        // A second start inside CALC must not disturb the division in flight.
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd50;
        divisor = 8'd3;
        exp_q.push_back(model(8'd50, 8'd3, cyc + 10));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        dividend = 8'h01;
        divisor = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        repeat (12) @(negedge clk);
        chk("repulse_queue_empty", exp_q.size(), 0);

        // start held through the done cycle launches the next division immediately.
        @(negedge clk);
        start = 1'b1;
        dividend = 8'hC3;
        divisor = 8'h0B;
        exp_q.push_back(model(8'hC3, 8'h0B, cyc + 10));
        k = 0;
        @(negedge clk);
        while (!done && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_first_done_seen", {31'b0, done}, 1);
        dividend = 8'h59;
        divisor = 8'hFD;
        exp_q.push_back(model(8'h59, 8'hFD, cyc + 10));
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        repeat (2) @(negedge clk);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Asynchronous abort partway through CALC.
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd77;
        divisor = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (3) @(negedge clk);
        chk_reset_outputs("abort_hold");
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", {31'b0, done}, 0);
        run(8'hB5, 8'h06);

        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(7) == 0) a = 8'h80;
            if ($urandom_range(7) == 0) b = 8'h00;
            else if ($urandom_range(7) == 0) b = 8'hFF;
            run(a, b);
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
